bm_output_arb3: RTL and testbench

- Round-robin arbiter for one bus-matrix output stage (master interface MIx), shared by three slave-interface input stages SI0–SI2.
- Each SI decoder raises a per-output select toward this block. The arbiter picks the owning input port for the address phase and returns an active_dec-style grant to each decoder.
- It tracks the data-phase owner so the output-stage mux routes response signals correctly.
- Grant is held for incremental bursts and locked sequences, so one output port is never split mid-burst.

---
 rtl/bm_pkg.sv | 16 +
 rtl/bm_rr_next3.sv | 36 +++
 rtl/bm_output_arb3.sv | 133 +++++++++++++
 tb/tb_bm_output_arb3.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared bus-matrix definitions: HTRANS encodings and input-port index sizing.
package bm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam int PORT_W = 2;
  localparam int NUM_SI = 3;

  typedef logic [PORT_W-1:0] port_idx_t;

endpackage

// File: rtl/bm_rr_next3.sv
// Combinational round-robin pick among three requesters, searching from the
// port after last_i and wrapping back to last_i itself.
module bm_rr_next3
  import bm_pkg::*;
(
  input  logic [NUM_SI-1:0] req_i,
  input  port_idx_t         last_i,
  output port_idx_t         next_o,
  output logic              any_o
);

  assign any_o = |req_i;

  always_comb begin
    next_o = last_i;
    case (last_i)
      2'd0: begin
        if      (req_i[1]) next_o = 2'd1;
        else if (req_i[2]) next_o = 2'd2;
        else if (req_i[0]) next_o = 2'd0;
      end
      2'd1: begin
        if      (req_i[2]) next_o = 2'd2;
        else if (req_i[0]) next_o = 2'd0;
        else if (req_i[1]) next_o = 2'd1;
      end
      default: begin
        // index 3 never occurs; treating it like 2 keeps the output legal
        if      (req_i[0]) next_o = 2'd0;
        else if (req_i[1]) next_o = 2'd1;
        else if (req_i[2]) next_o = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/bm_output_arb3.sv
// Output-stage arbiter for three slave-interface inputs with burst hold.
// Optional BM_ARB_LOCK_EN: HMASTLOCK also keeps ownership across NONSEQ/IDLE.
module bm_output_arb3
  import bm_pkg::*;
#(
  parameter int DEFAULT_PORT         = 0,
  parameter int LOCK_HOLD_CYCLES_MAX = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_op0,
  input  logic       req_op1,
  input  logic       req_op2,
  input  logic [1:0] trans_op0,
  input  logic [1:0] trans_op1,
  input  logic [1:0] trans_op2,
  input  logic       lock_op0,
  input  logic       lock_op1,
  input  logic       lock_op2,
  input  logic       HREADYM,
  output logic       active_op0,
  output logic       active_op1,
  output logic       active_op2,
  output logic [1:0] addr_in_port,
  output logic       no_port,
  output logic [1:0] data_in_port,
  output logic       data_no_port
);

  if (LOCK_HOLD_CYCLES_MAX != 0) begin : g_bad_lock_hold
    $error("bm_output_arb3: LOCK_HOLD_CYCLES_MAX must be 0");
  end
  if (DEFAULT_PORT < 0 || DEFAULT_PORT >= NUM_SI) begin : g_bad_default
    $error("bm_output_arb3: DEFAULT_PORT out of range");
  end

  localparam port_idx_t DEF_IDX = port_idx_t'(DEFAULT_PORT);

  port_idx_t         addr_q, addr_d, data_q, data_d;
  logic              no_port_q, no_port_d, data_no_q, data_no_d;
  logic [NUM_SI-1:0] req;
  logic              own_req;
  htrans_e           own_trans;
  logic              hold_burst, hold;
  port_idx_t         rr_next;
  logic              any_req;

  assign req = {req_op2, req_op1, req_op0};

  always_comb begin
    own_req   = 1'b0;
    own_trans = IDLE;
    case (addr_q)
      2'd0: begin own_req = req_op0; own_trans = htrans_e'(trans_op0); end
      2'd1: begin own_req = req_op1; own_trans = htrans_e'(trans_op1); end
      2'd2: begin own_req = req_op2; own_trans = htrans_e'(trans_op2); end
      default: ;
    endcase
  end

  assign hold_burst = own_req & ~no_port_q & ((own_trans == BUSY) | (own_trans == SEQ));

`ifdef BM_ARB_LOCK_EN
  logic own_lock;

  always_comb begin
    own_lock = 1'b0;
    case (addr_q)
      2'd0: own_lock = lock_op0;
      2'd1: own_lock = lock_op1;
      2'd2: own_lock = lock_op2;
      default: ;
    endcase
  end

  assign hold = hold_burst | (own_lock & own_req & ~no_port_q);
`else
  logic unused_lock;
  assign unused_lock = ^{lock_op0, lock_op1, lock_op2};
  assign hold = hold_burst;
`endif

  bm_rr_next3 u_rr (
    .req_i  (req),
    .last_i (addr_q),
    .next_o (rr_next),
    .any_o  (any_req)
  );

  // With no requester the owner index is kept so the rotation resumes fairly.
  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
    if (!hold) begin
      if (any_req) begin
        addr_d    = rr_next;
        no_port_d = 1'b0;
      end else begin
        no_port_d = 1'b1;
      end
    end
    data_d    = addr_q;
    data_no_d = no_port_q | ~own_req | (own_trans == IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q    <= DEF_IDX;
      no_port_q <= 1'b1;
      data_q    <= DEF_IDX;
      data_no_q <= 1'b1;
    end else if (HREADYM) begin
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      data_q    <= data_d;
      data_no_q <= data_no_d;
    end
  end

  assign active_op0   = ~no_port_q & (addr_q == 2'd0);
  assign active_op1   = ~no_port_q & (addr_q == 2'd1);
  assign active_op2   = ~no_port_q & (addr_q == 2'd2);
  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign data_in_port = data_q;
  assign data_no_port = data_no_q;

  a_active_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot0({active_op2, active_op1, active_op0}));
  a_addr_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
    addr_q != 2'd3);

endmodule

// File: tb/tb_bm_output_arb3.sv
// Bench for bm_output_arb3: directed vector table, lock and reset sequences,
// then random traffic against a behavioural round-robin model.
module tb_bm_output_arb3;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       req_op0, req_op1, req_op2;
  logic [1:0] trans_op0, trans_op1, trans_op2;
  logic       lock_op0, lock_op1, lock_op2;
  logic       HREADYM;
  logic       active_op0, active_op1, active_op2;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [1:0] data_in_port;
  logic       data_no_port;

  bm_output_arb3 #(.DEFAULT_PORT(0), .LOCK_HOLD_CYCLES_MAX(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_op0(req_op0), .req_op1(req_op1), .req_op2(req_op2),
    .trans_op0(trans_op0), .trans_op1(trans_op1), .trans_op2(trans_op2),
    .lock_op0(lock_op0), .lock_op1(lock_op1), .lock_op2(lock_op2),
    .HREADYM(HREADYM),
    .active_op0(active_op0), .active_op1(active_op1), .active_op2(active_op2),
    .addr_in_port(addr_in_port), .no_port(no_port),
    .data_in_port(data_in_port), .data_no_port(data_no_port)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // model: current owner and whether anyone owns the address / data phase
  int m_owner;
  bit m_none;
  int m_data;
  bit m_dnone;

  typedef struct {
    logic [2:0] req;
    logic [1:0] t0, t1, t2;
    logic       rdy;
    int         a;
    bit         nop;
    int         d;
    bit         dnop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] r, input logic [1:0] t0, t1, t2,
                              input logic rdy, input int a, input bit nop,
                              input int d, input bit dnop);
    vec_t v;
    v.req = r; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.rdy = rdy;
    v.a = a; v.nop = nop; v.d = d; v.dnop = dnop;
    return v;
  endfunction

  task automatic expect_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int a, input bit nop,
                           input int d, input bit dnop);
    int act_vec;
    act_vec = int'({active_op2, active_op1, active_op0});
    expect_eq({tag, " addr_in_port"}, int'(addr_in_port), a);
    expect_eq({tag, " no_port"}, int'(no_port), int'(nop));
    expect_eq({tag, " data_in_port"}, int'(data_in_port), d);
    expect_eq({tag, " data_no_port"}, int'(data_no_port), int'(dnop));
    expect_eq({tag, " active_op"}, act_vec, nop ? 0 : (1 << a));
  endtask

  task automatic model_reset();
    m_owner = 0; m_none = 1'b1; m_data = 0; m_dnone = 1'b1;
  endtask

  // Drive one cycle of inputs, let one edge happen, advance the model.
  task automatic step(input string tag, input logic [2:0] r,
                      input logic [1:0] t0, t1, t2, input logic [2:0] lk,
                      input logic rdy, input bit chk);
    logic [1:0] t[3];
    bit hold, found;
    int n_owner, n_data, p;
    bit n_none, n_dnone;
    req_op0 = r[0]; req_op1 = r[1]; req_op2 = r[2];
    trans_op0 = t0; trans_op1 = t1; trans_op2 = t2;
    lock_op0 = lk[0]; lock_op1 = lk[1]; lock_op2 = lk[2];
    HREADYM = rdy;
    t[0] = t0; t[1] = t1; t[2] = t2;
    n_owner = m_owner; n_none = m_none; n_data = m_data; n_dnone = m_dnone;
    if (rdy) begin
      hold = !m_none && r[m_owner] && (t[m_owner] == TB || t[m_owner] == TS);
`ifdef BM_ARB_LOCK_EN
      hold = hold || (!m_none && r[m_owner] && lk[m_owner]);
`endif
      n_data  = m_owner;
      n_dnone = m_none || !r[m_owner] || (t[m_owner] == TI);
      if (!hold) begin
        if (r == 3'b000) n_none = 1'b1;
        else begin
          found = 1'b0;
          for (int k = 1; k <= 3; k++) begin
            p = (m_owner + k) % 3;
            if (!found && r[p]) begin n_owner = p; found = 1'b1; end
          end
          n_none = 1'b0;
        end
      end
    end
    @(posedge HCLK);
    #1;
    m_owner = n_owner; m_none = n_none; m_data = n_data; m_dnone = n_dnone;
    if (chk) check_all(tag, m_owner, m_none, m_data, m_dnone);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    req_op0 = 0; req_op1 = 0; req_op2 = 0;
    trans_op0 = TI; trans_op1 = TI; trans_op2 = TI;
    lock_op0 = 0; lock_op1 = 0; lock_op2 = 0;
    HREADYM = 1'b1;
    model_reset();
    #12;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    int exp_own[5];
    vec_t v;

    // idle after reset
    for (int i = 0; i < 5; i++) vecs.push_back(mk(3'b000, TI, TI, TI, 1, 0, 1, 0, 1));
    // all three request NONSEQ: rotation 1,2,0,1
    vecs.push_back(mk(3'b111, TN, TN, TN, 1, 1, 0, 0, 1));
    vecs.push_back(mk(3'b111, TN, TN, TN, 1, 2, 0, 1, 0));
    vecs.push_back(mk(3'b111, TN, TN, TN, 1, 0, 0, 2, 0));
    vecs.push_back(mk(3'b111, TN, TN, TN, 1, 1, 0, 0, 0));
    // SI1 INCR4 while SI0 waits
    vecs.push_back(mk(3'b000, TI, TI, TI, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3'b010, TI, TN, TI, 1, 1, 0, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b011, TN, TS, TI, 1, 1, 0, 1, 0));
    vecs.push_back(mk(3'b001, TN, TI, TI, 1, 0, 0, 1, 1));
    // SI2 burst, then HREADYM low with inputs that would otherwise move the grant
    vecs.push_back(mk(3'b100, TN, TI, TN, 1, 2, 0, 0, 1));
    vecs.push_back(mk(3'b101, TN, TI, TS, 1, 2, 0, 2, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(3'b001, TN, TI, TI, 0, 2, 0, 2, 0));
    vecs.push_back(mk(3'b001, TN, TI, TI, 1, 0, 0, 2, 1));
    vecs.push_back(mk(3'b000, TI, TI, TI, 1, 0, 1, 0, 1));

    do_reset();
    #1;
    check_all("reset", 0, 1, 0, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step($sformatf("vec%0d", i), v.req, v.t0, v.t1, v.t2, 3'b000, v.rdy, 1'b0);
      check_all($sformatf("vec%0d", i), v.a, v.nop, v.d, v.dnop);
    end

    // locked NONSEQ,IDLE,NONSEQ from SI0 while SI2 requests
`ifdef BM_ARB_LOCK_EN
    exp_own = '{0, 0, 0, 0, 2};
`else
    exp_own = '{0, 2, 0, 2, 0};
`endif
    do_reset();
    step("lock a", 3'b001, TN, TI, TI, 3'b001, 1, 1'b1);
    expect_eq("lock a owner", int'(addr_in_port), exp_own[0]);
    step("lock b", 3'b101, TN, TI, TN, 3'b001, 1, 1'b1);
    expect_eq("lock b owner", int'(addr_in_port), exp_own[1]);
    step("lock c", 3'b101, TI, TI, TN, 3'b001, 1, 1'b1);
    expect_eq("lock c owner", int'(addr_in_port), exp_own[2]);
    step("lock d", 3'b101, TN, TI, TN, 3'b001, 1, 1'b1);
    expect_eq("lock d owner", int'(addr_in_port), exp_own[3]);
    step("lock e", 3'b101, TI, TI, TN, 3'b000, 1, 1'b1);
    expect_eq("lock e owner", int'(addr_in_port), exp_own[4]);

    // reset in the middle of an SI1 burst
    do_reset();
    step("mid a", 3'b010, TI, TN, TI, 3'b000, 1, 1'b1);
    step("mid b", 3'b010, TI, TS, TI, 3'b000, 1, 1'b1);
    expect_eq("mid owner before reset", int'(addr_in_port), 1);
    HRESETn = 1'b0;
    #1;
    model_reset();
    check_all("async reset", 0, 1, 0, 1);
    req_op1 = 1'b0; trans_op1 = TI;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step("post reset stall", 3'b100, TI, TI, TN, 3'b000, 0, 1'b1);
    expect_eq("post reset stall no_port", int'(no_port), 1);
    step("post reset grant", 3'b100, TI, TI, TN, 3'b000, 1, 1'b1);
    expect_eq("post reset grant owner", int'(addr_in_port), 2);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
